tick_divider_gen: RTL and testbench
===================================

Name: tick_divider_gen

Overview:
- Parametrised successor to the board clock divider. Generates single-cycle clock-enable strobes from clk_50m instead of derived clocks.
- Strobes produced: pixel enable, game tick, score tick. Game tick rate is selectable by a speed level.
- Sits between the board oscillator and the VGA/game/score logic. Everything downstream runs on clk_50m, gated by these enables, so no BUFG is required.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- PIX_DIV, 2, pixel enable period in clk_50m cycles (>=2).
- GAME_HZ, 8, game tick rate at level 0.
- SCORE_DIV, 8, game ticks per score tick (>=1).
- LEVELS, 4, number of speed levels. Level n divides the game period by 2^n.
- CNT_W, 24, game counter width. Must hold CLK_HZ/GAME_HZ-1.

Ports:
- clk_50m  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- pause  input  1  freezes game and score timing when high.
- level  input  clog2(LEVELS)  requested speed level.
- pix_en  output  1  one-cycle strobe every PIX_DIV cycles.
- game_tick  output  1  one-cycle game strobe.
- score_tick  output  1  one-cycle score strobe.
- game_phase  output  1  square wave; toggles on every game_tick.
- level_q  output  clog2(LEVELS)  currently applied level.

Behaviour:
- Reset and clocking
  - Single clock: clk_50m.
  - rst is synchronous and active-high. It is sampled at the clk_50m edge and overrides pause and all other inputs.
  - While rst is high, all counters and all outputs are 0, including level_q.
- Derived constants
  - BASE = CLK_HZ/GAME_HZ.
  - period = BASE >> level_q.
  - Elaboration check: BASE >> (LEVELS-1) must be >= 2.
- pix_en
  - Driven by a free-running counter, 0..PIX_DIV-1. pause does not affect it.
  - pix_en is registered and goes high for one cycle after the counter reaches PIX_DIV-1.
  - First pulse: PIX_DIV cycles after rst release.
- game counter
  - gcnt counts 0..period-1 and increments on every cycle where pause=0.
  - At gcnt==period-1 with pause=0: gcnt wraps to 0 and game_tick is registered high for the next cycle only.
  - First game_tick: period cycles after rst release.
  - game_phase toggles in the same cycle that game_tick is high.
- pause
  - gcnt, the score counter and game_phase hold their values.
  - No game_tick or score_tick is issued while pause is high.
  - If pause rises in the cycle gcnt==period-1, the wrap is withheld. The tick is issued one cycle after pause falls.
  - pix_en continues unaffected.
- level
  - level is sampled into level_q only on a wrap cycle. Changing level mid-period never shortens or lengthens the period in progress.
  - Requested values >= LEVELS clamp to LEVELS-1.
- score counter
  - scnt counts game ticks, 0..SCORE_DIV-1.
  - score_tick is high in the same cycle as the game_tick that completes SCORE_DIV ticks; scnt then wraps to 0.
  - With SCORE_DIV=1, score_tick equals game_tick.
- Output timing
  - All outputs are registered. No combinational path from inputs to outputs.
- Reset mid-operation
  - On the next edge, counters go to 0, any pending strobe is dropped and level_q goes to 0.

Optional Feature:
- Macro: TICK_SCORE_COUNT_EN.
- When defined:
  - Adds output score_count[15:0], which increments on each score_tick and saturates at 16'hFFFF.
  - Cleared by rst only. pause holds it.
- When not defined:
  - The port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Bench parameters: CLK_HZ=64, GAME_HZ=4 (BASE=16), PIX_DIV=2, SCORE_DIV=4, LEVELS=4.
- Reset release, level=0, pause=0 -> pix_en every 2nd cycle, first at cycle 2; game_tick at cycles 16, 32, 48, 64; score_tick only at cycle 64; game_phase toggles at each tick.
- level=2 applied at cycle 5 -> level_q becomes 2 at cycle 16; following ticks at cycles 20, 24, 28; period 4.
- pause high in cycles 10..19 -> game_tick delayed from cycle 16 to cycle 26; pix_en unchanged; score count unaffected.
- pause rising in the cycle gcnt==15 and released 3 cycles later -> exactly one game_tick, one cycle after release; no duplicate or lost tick.
- rst pulsed at cycle 40 with level_q=1 -> all outputs 0 next edge; level_q=0; next game_tick 16 cycles after release.
- Optional feature, TICK_SCORE_COUNT_EN defined, run 6400 cycles -> score_count=100; pause does not change it; rst clears it to 0.

Source files
------------

// File: rtl/tick_divider_gen.sv
// Clock-enable strobe generator: pixel enable, game tick (level-selectable rate) and score tick, all on clk_50m.
// Optional macro TICK_SCORE_COUNT_EN adds a saturating 16-bit score_count output.
module tick_divider_gen #(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned PIX_DIV   = 2,
   parameter int unsigned GAME_HZ   = 8,
   parameter int unsigned SCORE_DIV = 8,
   parameter int unsigned LEVELS    = 4,
   parameter int unsigned CNT_W     = 24,
   localparam int unsigned LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             pause,
   input  logic [LVL_W-1:0] level,
   output logic             pix_en,
   output logic             game_tick,
   output logic             score_tick,
   output logic             game_phase,
   output logic [LVL_W-1:0] level_q
`ifdef TICK_SCORE_COUNT_EN
   ,
   output logic [15:0]      score_count
`endif
);

   localparam int unsigned BASE_I = CLK_HZ / GAME_HZ;
   localparam int unsigned PW     = $clog2(PIX_DIV);
   localparam int unsigned SW     = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

   localparam logic [CNT_W-1:0] BASE       = CNT_W'(BASE_I);
   localparam logic [PW-1:0]    PIX_LAST   = PW'(PIX_DIV - 1);
   localparam logic [SW-1:0]    SCORE_LAST = SW'(SCORE_DIV - 1);
   localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(LEVELS - 1);

   if ((BASE_I >> (LEVELS - 1)) < 2) begin : g_chk_base
      $error("tick_divider_gen: fastest game period must be at least 2 cycles");
   end
   if (((BASE_I - 1) >> CNT_W) != 0) begin : g_chk_cnt_w
      $error("tick_divider_gen: CNT_W too narrow for CLK_HZ/GAME_HZ-1");
   end
   if (PIX_DIV < 2) begin : g_chk_pix
      $error("tick_divider_gen: PIX_DIV must be >= 2");
   end
   if (SCORE_DIV < 1) begin : g_chk_score
      $error("tick_divider_gen: SCORE_DIV must be >= 1");
   end

   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [CNT_W-1:0] gcnt_q, gcnt_d;
   logic [SW-1:0]    scnt_q, scnt_d;
   logic             pix_en_q, pix_en_d;
   logic             game_tick_q, game_tick_d;
   logic             score_tick_q, score_tick_d;
   logic             phase_q, phase_d;
   logic [LVL_W-1:0] level_d;
   logic [LVL_W-1:0] level_clamped;
   logic [31:0]      level_ext;
   logic [CNT_W-1:0] period_m1;
`ifdef TICK_SCORE_COUNT_EN
   logic [15:0]      score_count_q, score_count_d;
`endif

   always_comb begin
      level_ext     = 32'(level);
      level_clamped = (level_ext >= 32'(LEVELS)) ? LVL_MAX : level;
      period_m1     = (BASE >> level_q) - CNT_W'(1);

      pcnt_d       = pcnt_q;
      pix_en_d     = 1'b0;
      gcnt_d       = gcnt_q;
      scnt_d       = scnt_q;
      game_tick_d  = 1'b0;
      score_tick_d = 1'b0;
      phase_d      = phase_q;
      level_d      = level_q;
`ifdef TICK_SCORE_COUNT_EN
      score_count_d = score_count_q;
`endif

      if (pcnt_q == PIX_LAST) begin
         pcnt_d   = '0;
         pix_en_d = 1'b1;
      end else begin
         pcnt_d = pcnt_q + PW'(1);
      end

      // A wrap held off by pause stays pending at period-1 until pause drops.
      if (!pause) begin
         if (gcnt_q == period_m1) begin
            gcnt_d      = '0;
            game_tick_d = 1'b1;
            phase_d     = ~phase_q;
            level_d     = level_clamped;
            if (scnt_q == SCORE_LAST) begin
               scnt_d       = '0;
               score_tick_d = 1'b1;
`ifdef TICK_SCORE_COUNT_EN
               if (score_count_q != '1) begin
                  score_count_d = score_count_q + 16'd1;
               end
`endif
            end else begin
               scnt_d = scnt_q + SW'(1);
            end
         end else begin
            gcnt_d = gcnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         pcnt_q       <= '0;
         gcnt_q       <= '0;
         scnt_q       <= '0;
         pix_en_q     <= 1'b0;
         game_tick_q  <= 1'b0;
         score_tick_q <= 1'b0;
         phase_q      <= 1'b0;
         level_q      <= '0;
`ifdef TICK_SCORE_COUNT_EN
         score_count_q <= '0;
`endif
      end else begin
         pcnt_q       <= pcnt_d;
         gcnt_q       <= gcnt_d;
         scnt_q       <= scnt_d;
         pix_en_q     <= pix_en_d;
         game_tick_q  <= game_tick_d;
         score_tick_q <= score_tick_d;
         phase_q      <= phase_d;
         level_q      <= level_d;
`ifdef TICK_SCORE_COUNT_EN
         score_count_q <= score_count_d;
`endif
      end
   end

   assign pix_en     = pix_en_q;
   assign game_tick  = game_tick_q;
   assign score_tick = score_tick_q;
   assign game_phase = phase_q;
`ifdef TICK_SCORE_COUNT_EN
   assign score_count = score_count_q;
`endif

endmodule

// File: tb/tb_tick_divider_gen.sv
// Self-checking bench for tick_divider_gen against a countdown-style reference model.
// Define TICK_SCORE_COUNT_EN to also exercise the score_count output.
module tb_tick_divider_gen;

   localparam int unsigned CLK_HZ    = 64;
   localparam int unsigned GAME_HZ   = 4;
   localparam int unsigned PIX_DIV   = 2;
   localparam int unsigned SCORE_DIV = 4;
   localparam int unsigned LEVELS    = 4;
   localparam int unsigned CNT_W     = 8;
   localparam int          BASE      = CLK_HZ / GAME_HZ;

   logic       clk_50m = 1'b0;
   logic       rst     = 1'b1;
   logic       pause   = 1'b0;
   logic [1:0] level   = 2'd0;
   logic       pix_en, game_tick, score_tick, game_phase;
   logic [1:0] level_q;
`ifdef TICK_SCORE_COUNT_EN
   logic [15:0] score_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   tick_divider_gen #(
      .CLK_HZ(CLK_HZ), .PIX_DIV(PIX_DIV), .GAME_HZ(GAME_HZ),
      .SCORE_DIV(SCORE_DIV), .LEVELS(LEVELS), .CNT_W(CNT_W)
   ) dut (
      .clk_50m(clk_50m), .rst(rst), .pause(pause), .level(level),
      .pix_en(pix_en), .game_tick(game_tick), .score_tick(score_tick),
      .game_phase(game_phase), .level_q(level_q)
`ifdef TICK_SCORE_COUNT_EN
      , .score_count(score_count)
`endif
   );

   always #5 clk_50m = ~clk_50m;

   // Reference model: cycles since release, unpaused cycles left until the next tick, tick tally.
   int   m_k, m_rem, m_lvl, m_ticks, m_scount;
   bit   m_phase, e_pix, e_game, e_score;
   logic [5:0] exp_v, obs_v;

   task automatic step();
      bit r, p;
      int l;
      r = rst; p = pause; l = int'(level);
      @(posedge clk_50m);
      #1;
      e_pix = 0; e_game = 0; e_score = 0;
      if (r) begin
         m_k = 0; m_rem = BASE; m_lvl = 0; m_ticks = 0; m_scount = 0; m_phase = 0;
      end else begin
         m_k++;
         e_pix = ((m_k % PIX_DIV) == 0);
         if (!p) begin
            m_rem--;
            if (m_rem == 0) begin
               e_game  = 1;
               m_phase = !m_phase;
               m_ticks++;
               if ((m_ticks % SCORE_DIV) == 0) begin
                  e_score = 1;
                  if (m_scount < 65535) m_scount++;
               end
               m_lvl = (l > int'(LEVELS) - 1) ? int'(LEVELS) - 1 : l;
               m_rem = BASE >> m_lvl;
            end
         end
      end
      exp_v = {e_pix, e_game, e_score, m_phase, 2'(m_lvl)};
      obs_v = {pix_en, game_tick, score_tick, game_phase, level_q};
   endtask

   task automatic do_reset();
      rst = 1; pause = 0; level = 0;
      repeat (3) step();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; pause = 1; level = 3;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if (obs_v !== 6'b0) begin
            n_fail++;
            $display("FAIL reset cycle %0d: outputs %b, want 000000", c, obs_v);
         end
      end
      pause = 0; level = 0;
   endtask

   task automatic test_free_run();
      logic [127:0] gm, sm, egm, esm;
      gm = '0; sm = '0; egm = '0; esm = '0;
      egm[16] = 1; egm[32] = 1; egm[48] = 1; egm[64] = 1; esm[64] = 1;
      do_reset();
      for (int c = 1; c <= 70; c++) begin
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL free_run cycle %0d: outputs %b, want %b", c, obs_v, exp_v);
         end
         if (game_tick === 1'b1 && c < 128) gm[c] = 1;
         if (score_tick === 1'b1 && c < 128) sm[c] = 1;
      end
      n_checks++;
      if (gm !== egm) begin n_fail++; $display("FAIL free_run game ticks: got %h, want %h", gm, egm); end
      n_checks++;
      if (sm !== esm) begin n_fail++; $display("FAIL free_run score ticks: got %h, want %h", sm, esm); end
   endtask

   task automatic test_level();
      logic [127:0] gm, egm;
      gm = '0; egm = '0;
      egm[16] = 1; egm[20] = 1; egm[24] = 1; egm[28] = 1;
      do_reset();
      for (int c = 1; c <= 28; c++) begin
         if (c == 5) level = 2;
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL level cycle %0d: outputs %b, want %b", c, obs_v, exp_v);
         end
         if (c == 15) begin
            n_checks++;
            if (level_q !== 2'd0) begin n_fail++; $display("FAIL level_q mid-period: got %0d, want 0", level_q); end
         end
         if (c == 16) begin
            n_checks++;
            if (level_q !== 2'd2) begin n_fail++; $display("FAIL level_q at wrap: got %0d, want 2", level_q); end
         end
         if (game_tick === 1'b1) gm[c] = 1;
      end
      n_checks++;
      if (gm !== egm) begin n_fail++; $display("FAIL level game ticks: got %h, want %h", gm, egm); end
      level = 0;
   endtask

   task automatic test_pause();
      logic [127:0] gm, egm;
      int pc;
      gm = '0; egm = '0; pc = 0;
      egm[26] = 1;
      do_reset();
      for (int c = 1; c <= 30; c++) begin
         pause = (c >= 10 && c <= 19);
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL pause cycle %0d: outputs %b, want %b", c, obs_v, exp_v);
         end
         if (game_tick === 1'b1) gm[c] = 1;
         if (pix_en === 1'b1) pc++;
      end
      pause = 0;
      n_checks++;
      if (gm !== egm) begin n_fail++; $display("FAIL pause game ticks: got %h, want %h", gm, egm); end
      n_checks++;
      if (pc != 15) begin n_fail++; $display("FAIL pause pix_en count: got %0d, want 15", pc); end
   endtask

   task automatic test_pause_at_wrap();
      logic [127:0] gm, egm;
      gm = '0; egm = '0;
      egm[19] = 1;
      do_reset();
      for (int c = 1; c <= 30; c++) begin
         pause = (c >= 16 && c <= 18);
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL pause_wrap cycle %0d: outputs %b, want %b", c, obs_v, exp_v);
         end
         if (game_tick === 1'b1) gm[c] = 1;
      end
      pause = 0;
      n_checks++;
      if (gm !== egm) begin n_fail++; $display("FAIL pause_wrap game ticks: got %h, want %h", gm, egm); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] gm, egm;
      gm = '0; egm = '0;
      egm[16] = 1; egm[24] = 1; egm[32] = 1; egm[56] = 1;
      do_reset();
      level = 1;
      for (int c = 1; c <= 58; c++) begin
         rst = (c == 40);
         if (c == 41) level = 0;
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid cycle %0d: outputs %b, want %b", c, obs_v, exp_v);
         end
         if (c == 39) begin
            n_checks++;
            if (level_q !== 2'd1) begin n_fail++; $display("FAIL reset_mid level_q before rst: got %0d, want 1", level_q); end
         end
         if (c == 40) begin
            n_checks++;
            if (obs_v !== 6'b0) begin n_fail++; $display("FAIL reset_mid outputs at rst: got %b, want 000000", obs_v); end
         end
         if (game_tick === 1'b1) gm[c] = 1;
      end
      rst = 0;
      n_checks++;
      if (gm !== egm) begin n_fail++; $display("FAIL reset_mid game ticks: got %h, want %h", gm, egm); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 1; c <= 3000; c++) begin
         pause = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) level = 2'($urandom_range(0, 3));
         step();
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL random cycle %0d: outputs %b, want %b", c, obs_v, exp_v);
         end
`ifdef TICK_SCORE_COUNT_EN
         n_checks++;
         if (score_count !== 16'(m_scount)) begin
            n_fail++;
            $display("FAIL random score_count cycle %0d: got %0d, want %0d", c, score_count, m_scount);
         end
`endif
      end
      rst = 0; pause = 0; level = 0;
   endtask

`ifdef TICK_SCORE_COUNT_EN
   task automatic test_score_count();
      do_reset();
      repeat (6400) step();
      n_checks++;
      if (score_count !== 16'd100) begin n_fail++; $display("FAIL score_count after 6400: got %0d, want 100", score_count); end
      n_checks++;
      if (score_count !== 16'(m_scount)) begin n_fail++; $display("FAIL score_count vs model: got %0d, want %0d", score_count, m_scount); end
      pause = 1;
      repeat (200) step();
      pause = 0;
      n_checks++;
      if (score_count !== 16'd100) begin n_fail++; $display("FAIL score_count under pause: got %0d, want 100", score_count); end
      rst = 1;
      step();
      rst = 0;
      n_checks++;
      if (score_count !== 16'd0) begin n_fail++; $display("FAIL score_count after rst: got %0d, want 0", score_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_free_run();
      test_level();
      test_pause();
      test_pause_at_wrap();
      test_reset_mid();
      test_random();
`ifdef TICK_SCORE_COUNT_EN
      test_score_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
